// File: rtl/dmem_access_ctrl.sv
// Data-memory bus controller sitting behind the MEM stage.
// Converts load/store requests into word-aligned bus transactions, performs
// read-modify-write for sub-word stores (merge done by the MEM stage), holds
// the pipeline while an access is in flight and aborts on a bus timeout.
module dmem_access_ctrl #(
  parameter int P_TIMEOUT = 255
) (
  input  logic        i_Clk_1,
  input  logic        i_Rstn_1,
  input  logic        i_Load_1,
  input  logic        i_Store_1,
  input  logic [1:0]  i_LoadStoreWidth_2,
  input  logic [31:0] i_ALUResult_32,
  input  logic [31:0] i_MemoryStoreData_32,
  output logic [31:0] o_MemoryLoadData_32,
  output logic        o_Stall_1,
  output logic        o_BusReq_1,
  output logic        o_BusWe_1,
  output logic [31:0] o_BusAddr_32,
  output logic [31:0] o_BusWData_32,
  input  logic        i_BusAck_1,
  input  logic [31:0] i_BusRData_32,
  output logic        o_BusError_1
);

  // Wide enough to hold P_TIMEOUT; the counter only ever reaches P_TIMEOUT-1.
  localparam int CNT_W = $clog2(P_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic        bus_err_q, bus_err_d;
  logic        is_store_q, is_store_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ack_v;
  logic cnt_expired;
  logic mem_req;
  logic is_word;

  // The byte/half distinction only matters for lane selection, which the
  // MEM stage owns; the controller only needs to know word vs. sub-word.
  logic unused_width_lsb;
  assign unused_width_lsb = i_LoadStoreWidth_2[0];

  assign mem_req     = i_Load_1 | i_Store_1;
  assign is_word     = i_LoadStoreWidth_2[1];
  // An ack is only meaningful while a request is actually on the bus.
  assign ack_v       = i_BusAck_1 & bus_req_q;
  // Last request cycle that may still complete; no ack here means abort.
  assign cnt_expired = (cnt_q == CNT_W'(P_TIMEOUT - 1));

  // Registered outputs straight from their flops.
  assign o_BusReq_1          = bus_req_q;
  assign o_BusWe_1           = bus_we_q;
  assign o_BusError_1        = bus_err_q;
  assign o_BusAddr_32        = bus_addr_q;
  assign o_BusWData_32       = bus_wdata_q;
  assign o_MemoryLoadData_32 = load_data_q;

  // Pipeline hold: busy states always stall, IDLE stalls only when a memory
  // instruction is waiting, DONE releases the pipeline for one cycle.
  always_comb begin
    o_Stall_1 = 1'b0;
    case (state_q)
      S_IDLE:  o_Stall_1 = mem_req;
      S_READ,
      S_MERGE,
      S_WRITE: o_Stall_1 = 1'b1;
      default: o_Stall_1 = 1'b0;
    endcase
  end

  // Next-state and next-value logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_err_d   = 1'b0;
    is_store_d  = is_store_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    load_data_d = load_data_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          bus_addr_d  = {i_ALUResult_32[31:2], 2'b00};
          bus_wdata_d = i_MemoryStoreData_32;
          // Load wins when both strobes are high.
          is_store_d  = ~i_Load_1;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          if (!i_Load_1 && is_word) begin
            // Full-word store needs no read of the old contents.
            state_d  = S_WRITE;
            bus_we_d = 1'b1;
          end else begin
            state_d  = S_READ;
            bus_we_d = 1'b0;
          end
        end
      end

      S_READ: begin
        if (ack_v) begin
          load_data_d = i_BusRData_32;
          bus_req_d   = 1'b0;
          state_d     = is_store_q ? S_MERGE : S_DONE;
        end else if (cnt_expired) begin
          // Abort: no data, and a pending sub-word store is dropped.
          load_data_d = '0;
          bus_req_d   = 1'b0;
          bus_err_d   = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_MERGE: begin
        // The MEM stage has had a cycle to merge the fetched word.
        bus_wdata_d = i_MemoryStoreData_32;
        cnt_d       = '0;
        bus_req_d   = 1'b1;
        bus_we_d    = 1'b1;
        state_d     = S_WRITE;
      end

      S_WRITE: begin
        if (ack_v) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_expired) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // Requests seen here belong to the instruction already completing.
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
        bus_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_Clk_1) begin
    if (!i_Rstn_1) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      is_store_q  <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      load_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_err_q   <= bus_err_d;
      is_store_q  <= is_store_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      load_data_q <= load_data_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
